// File: rtl/mdio_pkg.sv
// Shared types and constants for the clause-22 MDIO PHY responder.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE, START, OP, ADDR, TA, WDATA, RDATA, SKIP
    } mdio_state_e;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] TA_WR    = 2'b10;

    localparam int unsigned PHYAD_W  = 5;
    localparam int unsigned REGAD_W  = 5;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 32;

    // Bit positions within the 32-bit frame body (ST first bit = 0).
    localparam logic [4:0] POS_OP_END   = 5'd3;
    localparam logic [4:0] POS_ADDR_END = 5'd13;
    localparam logic [4:0] POS_TA0      = 5'd14;
    localparam logic [4:0] POS_TA1      = 5'd15;
    localparam logic [4:0] POS_LAST     = 5'd31;

endpackage

// File: rtl/mdio_phy_responder_if.sv
// MDIO pad-side bus between a MAC management master and the PHY responder.
interface mdio_phy_responder_if;
    logic mdc;
    logic mdio_in;
    logic mdio_out;
    logic mdio_oe;

    modport slave  (input mdc, mdio_in, output mdio_out, mdio_oe);
    modport master (output mdc, mdio_in, input mdio_out, mdio_oe);
endinterface

// File: rtl/mdc_sync_edge.sv
// Two-flop synchronizer for an asynchronous clock-like input with rise/fall pulses.
module mdc_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (reset) sh <= '0;
        else       sh <= {sh[1:0], async_in};
    end

    assign rise = sh[1] & ~sh[2];
    assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO slave: oversampled frame decoder, 32x16 register bank, read drive.
module mdio_phy_responder
    import mdio_pkg::*;
#(
    parameter int unsigned PRE_LEN     = 32,
    parameter bit          REGAD_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PHYAD_W-1:0]    phy_address,
    mdio_phy_responder_if.slave   mdio,
    output logic                  wr_strobe,
    output logic [REGAD_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  rd_strobe,
    output logic                  busy
);
    localparam int unsigned CW = (PRE_LEN < 1) ? 1 : $clog2(PRE_LEN + 1);
    localparam logic [CW-1:0] PRE_SAT = CW'(PRE_LEN);

    logic mdc_rise, mdc_fall;
    logic [1:0] mdio_sync;
    logic mdio_s;

    mdio_state_e state, state_n;
    logic [CW-1:0]     pre_cnt, pre_n;
    logic [4:0]        pos, pos_n;
    logic [1:0]        op, op_n;
    logic [9:0]        addr_sh, addr_n;
    logic [DATA_W-1:0] data_sh, data_n;
    logic [4:0]        rd_cnt, rd_cnt_n;
    logic              out_r, out_n, oe_r, oe_n;
    logic              rd_stb_n, commit;
    logic              pre_ok;
    logic [DATA_W-1:0] bank [NUM_REGS];

    function automatic logic [4:0] regad_of(input logic [9:0] a);
        return REGAD_FIRST ? a[9:5] : a[4:0];
    endfunction

    function automatic logic [4:0] phyad_of(input logic [9:0] a);
        return REGAD_FIRST ? a[4:0] : a[9:5];
    endfunction

    mdc_sync_edge u_mdc_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (mdio.mdc),
        .rise     (mdc_rise),
        .fall     (mdc_fall)
    );

    // Same depth as the mdc path so data sampled at a detected rise is aligned.
    assign mdio_s = mdio_sync[1];
    assign pre_ok = (pre_cnt >= PRE_SAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            mdio_sync <= '0;
            state     <= IDLE;
            pre_cnt   <= '0;
            pos       <= '0;
            op        <= '0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rd_cnt    <= '0;
            out_r     <= 1'b1;
            oe_r      <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) bank[i] <= '0;
        end else begin
            mdio_sync <= {mdio_sync[0], mdio.mdio_in};
            state     <= state_n;
            pre_cnt   <= pre_n;
            pos       <= pos_n;
            op        <= op_n;
            addr_sh   <= addr_n;
            data_sh   <= data_n;
            rd_cnt    <= rd_cnt_n;
            out_r     <= out_n;
            oe_r      <= oe_n;
            wr_strobe <= commit;
            rd_strobe <= rd_stb_n;
            if (commit) begin
                bank[regad_of(addr_sh)] <= data_n;
                wr_addr                 <= regad_of(addr_sh);
                wr_data                 <= data_n;
            end
        end
    end

    always_comb begin
        state_n  = state;
        pre_n    = pre_cnt;
        pos_n    = pos;
        op_n     = op;
        addr_n   = addr_sh;
        data_n   = data_sh;
        rd_cnt_n = rd_cnt;
        out_n    = out_r;
        oe_n     = oe_r;
        rd_stb_n = 1'b0;
        commit   = 1'b0;
        if (mdc_rise) begin
            pos_n = pos + 5'd1;
            unique case (state)
                IDLE: begin
                    pos_n = '0;
                    if (mdio_s == ST[1]) begin
                        if (pre_ok) begin
                            state_n = START;
                            pos_n   = 5'd1;
                        end
                        pre_n = '0;
                    end else if (!pre_ok) begin
                        pre_n = pre_cnt + CW'(1);
                    end
                end
                START: begin
                    if (mdio_s == ST[0]) state_n = OP;
                    else begin
                        state_n = IDLE;
                        pre_n   = '0;
                    end
                end
                OP: begin
                    op_n = {op[0], mdio_s};
                    if (pos == POS_OP_END)
                        state_n = (op_n == OP_WRITE || op_n == OP_READ) ? ADDR : SKIP;
                end
                ADDR: begin
                    addr_n = {addr_sh[8:0], mdio_s};
                    if (pos == POS_ADDR_END) begin
                        if (phyad_of(addr_n) != phy_address) state_n = SKIP;
                        else begin
                            state_n = TA;
                            if (op == OP_READ) begin
                                rd_stb_n = 1'b1;
                                data_n   = bank[regad_of(addr_n)];
                            end
                        end
                    end
                end
                TA: begin
                    if (op == OP_WRITE) begin
                        if (pos == POS_TA0 && mdio_s != TA_WR[1]) state_n = SKIP;
                        if (pos == POS_TA1) state_n = (mdio_s == TA_WR[0]) ? WDATA : SKIP;
                    end
                end
                WDATA: begin
                    data_n = {data_sh[DATA_W-2:0], mdio_s};
                    if (pos == POS_LAST) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                        pre_n   = '0;
                    end
                end
                RDATA: ;
                SKIP: begin
                    if (pos == POS_LAST) begin
                        state_n = IDLE;
                        pre_n   = '0;
                    end
                end
            endcase
        end else if (mdc_fall) begin
            // Drive window: TA bit 1 plus 16 data bits, released on the 17th fall.
            if (state == TA && op == OP_READ && pos == POS_TA1) begin
                oe_n     = 1'b1;
                out_n    = 1'b0;
                state_n  = RDATA;
                rd_cnt_n = '0;
            end else if (state == RDATA) begin
                if (rd_cnt == 5'd16) begin
                    oe_n    = 1'b0;
                    out_n   = 1'b1;
                    state_n = IDLE;
                    pre_n   = '0;
                end else begin
                    out_n    = data_sh[DATA_W-1];
                    data_n   = {data_sh[DATA_W-2:0], 1'b0};
                    rd_cnt_n = rd_cnt + 5'd1;
                end
            end
        end
    end

    assign mdio.mdio_out = out_r;
    assign mdio.mdio_oe  = oe_r;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed + random bench: a behavioural MDIO master and register-bank model drive three responders.
module tb_mdio_phy_responder;
    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] OP_R = 2'b10;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] phy_address = 5'd7;
    logic mdc_m = 1'b0;
    logic mdio_m = 1'b1;
    int sel = 0;

    always #5 clk = ~clk;

    mdio_phy_responder_if mif0();
    mdio_phy_responder_if mif1();
    mdio_phy_responder_if mif2();

    logic        ws [3];
    logic [4:0]  wa [3];
    logic [15:0] wd [3];
    logic        rs [3];
    logic        bz [3];

    assign mif0.mdc = mdc_m & (sel == 0);
    assign mif1.mdc = mdc_m & (sel == 1);
    assign mif2.mdc = mdc_m & (sel == 2);
    assign mif0.mdio_in = mif0.mdio_oe ? mif0.mdio_out : mdio_m;
    assign mif1.mdio_in = mif1.mdio_oe ? mif1.mdio_out : mdio_m;
    assign mif2.mdio_in = mif2.mdio_oe ? mif2.mdio_out : mdio_m;

    mdio_phy_responder #(.PRE_LEN(32), .REGAD_FIRST(1'b0)) dut0 (
        .clk(clk), .reset(reset), .phy_address(phy_address), .mdio(mif0),
        .wr_strobe(ws[0]), .wr_addr(wa[0]), .wr_data(wd[0]), .rd_strobe(rs[0]), .busy(bz[0]));
    mdio_phy_responder #(.PRE_LEN(0), .REGAD_FIRST(1'b0)) dut1 (
        .clk(clk), .reset(reset), .phy_address(phy_address), .mdio(mif1),
        .wr_strobe(ws[1]), .wr_addr(wa[1]), .wr_data(wd[1]), .rd_strobe(rs[1]), .busy(bz[1]));
    mdio_phy_responder #(.PRE_LEN(32), .REGAD_FIRST(1'b1)) dut2 (
        .clk(clk), .reset(reset), .phy_address(phy_address), .mdio(mif2),
        .wr_strobe(ws[2]), .wr_addr(wa[2]), .wr_data(wd[2]), .rd_strobe(rs[2]), .busy(bz[2]));

    logic bus, cur_oe, cur_out;
    always_comb begin
        bus = mif0.mdio_in; cur_oe = mif0.mdio_oe; cur_out = mif0.mdio_out;
        if (sel == 1) begin bus = mif1.mdio_in; cur_oe = mif1.mdio_oe; cur_out = mif1.mdio_out; end
        if (sel == 2) begin bus = mif2.mdio_in; cur_oe = mif2.mdio_oe; cur_out = mif2.mdio_out; end
    end

    int ws_cnt [3] = '{0, 0, 0};
    int rs_cnt [3] = '{0, 0, 0};
    int oe_cyc [3] = '{0, 0, 0};
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ws[k]) ws_cnt[k]++;
            if (rs[k]) rs_cnt[k]++;
        end
        if (mif0.mdio_oe) oe_cyc[0]++;
        if (mif1.mdio_oe) oe_cyc[1]++;
        if (mif2.mdio_oe) oe_cyc[2]++;
    end

    logic [15:0] model [3][32];
    int passed = 0;
    int total = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (failure %0d)", tag, obs, exp, failed);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < 32; r++) model[k][r] = 16'h0000;
    endtask

    task automatic mdc_bit(input logic b, output logic s);
        mdio_m = b;
        repeat (HALF) @(negedge clk);
        s = bus;
        mdc_m = 1'b1;
        repeat (HALF) @(negedge clk);
        mdc_m = 1'b0;
    endtask

    task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] ra, input logic [15:0] wdat, input bit rf,
                         input int abort_at, output logic [15:0] rd, output logic ta);
        logic s;
        logic [31:0] body;
        logic [9:0] af;
        af = rf ? {ra, phy} : {phy, ra};
        if (op == OP_R) body = {2'b01, op, af, 2'b11, 16'hFFFF};
        else            body = {2'b01, op, af, 2'b10, wdat};
        rd = '0;
        ta = 1'b1;
        for (int i = 0; i < pre; i++) mdc_bit(1'b1, s);
        for (int i = 31; i >= 0; i--) begin
            if (abort_at >= 0 && i == 15 - abort_at) begin
                mdio_m = 1'b1;
                repeat (HALF) @(negedge clk);
                mdc_m = 1'b1;
                repeat (2) @(negedge clk);
                chk("abort_oe_before", 32'(cur_oe), 1);
                chk("abort_busy_before", 32'(bz[sel]), 1);
                reset = 1'b1;
                @(posedge clk); #1;
                chk("abort_oe_after", 32'(cur_oe), 0);
                chk("abort_out_after", 32'(cur_out), 1);
                chk("abort_busy_after", 32'(bz[sel]), 0);
                @(negedge clk);
                reset = 1'b0;
                mdc_m = 1'b0;
                repeat (2 * HALF) @(negedge clk);
                return;
            end
            mdc_bit(body[i], s);
            if (i == 16) ta = s;
            if (i < 16) rd[i] = s;
        end
        mdio_m = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic do_write(input int k, input int pre, input int pre_len, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d,
                            input bit rf);
        int ws0, oe0;
        bit accept;
        logic [15:0] rdd;
        logic tab;
        sel = k;
        ws0 = ws_cnt[k];
        oe0 = oe_cyc[k];
        accept = (pre >= pre_len) && (op == OP_W) && (phy == phy_address);
        frame(pre, op, phy, ra, d, rf, -1, rdd, tab);
        chk("wr_strobe_count", ws_cnt[k] - ws0, accept ? 1 : 0);
        if (accept) begin
            chk("wr_addr", 32'(wa[k]), 32'(ra));
            chk("wr_data", 32'(wd[k]), 32'(d));
            model[k][ra] = d;
        end
        chk("wr_no_drive", oe_cyc[k] - oe0, 0);
        chk("busy_after_wr", 32'(bz[k]), 0);
    endtask

    task automatic do_read(input int k, input int pre, input logic [4:0] ra, input bit rf);
        int rs0, oe0;
        logic [15:0] rdd;
        logic tab;
        sel = k;
        rs0 = rs_cnt[k];
        oe0 = oe_cyc[k];
        frame(pre, OP_R, phy_address, ra, 16'h0000, rf, -1, rdd, tab);
        chk("rd_data", 32'(rdd), 32'(model[k][ra]));
        chk("rd_ta_zero", 32'(tab), 0);
        chk("rd_oe_window", oe_cyc[k] - oe0, 17 * 2 * HALF);
        chk("rd_strobe_count", rs_cnt[k] - rs0, 1);
        chk("busy_after_rd", 32'(bz[k]), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rdd;
        logic tab;
        logic [4:0] r;
        logic [15:0] d;
        model_clear();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_oe", 32'(mif0.mdio_oe), 0);
        chk("rst_out", 32'(mif0.mdio_out), 1);
        chk("rst_busy", 32'(bz[0]), 0);
        chk("rst_wr_strobe", 32'(ws[0]), 0);
        chk("rst_wr_addr", 32'(wa[0]), 0);
        chk("rst_wr_data", 32'(wd[0]), 0);
        chk("rst_rd_strobe", 32'(rs[0]), 0);

        // Basic write then read-back with drive-window check.
        do_write(0, 32, 32, OP_W, 5'd7, 5'd5, 16'hA5C3, 1'b0);
        do_read(0, 32, 5'd5, 1'b0);

        // Foreign PHY address is ignored.
        do_write(0, 32, 32, OP_W, 5'd3, 5'd2, 16'h1234, 1'b0);
        do_read(0, 32, 5'd2, 1'b0);

        // Short preamble ignored; the same frame commits with preamble suppression.
        do_write(0, 31, 32, OP_W, 5'd7, 5'd6, 16'hBEEF, 1'b0);
        do_read(0, 32, 5'd6, 1'b0);
        do_write(1, 31, 0, OP_W, 5'd7, 5'd6, 16'hBEEF, 1'b0);
        do_read(1, 0, 5'd6, 1'b0);

        // Invalid opcode skipped, following valid write commits.
        do_write(0, 32, 32, 2'b11, 5'd7, 5'd9, 16'h00FF, 1'b0);
        do_write(0, 32, 32, OP_W, 5'd7, 5'd9, 16'h00FF, 1'b0);
        do_read(0, 32, 5'd9, 1'b0);

        // Reset mid read data; the bank is cleared by reset.
        sel = 0;
        frame(32, OP_R, 5'd7, 5'd5, 16'h0000, 1'b0, 8, rdd, tab);
        model_clear();
        do_read(0, 32, 5'd5, 1'b0);

        // Random traffic, clause-22 order.
        for (int i = 0; i < 32; i++) begin
            d = 16'($urandom);
            do_write(0, 32, 32, OP_W, 5'd7, 5'(i), d, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            r = 5'($urandom_range(0, 31));
            do_read(0, 32, r, 1'b0);
        end

        // Random traffic, REGAD-first order.
        for (int i = 0; i < 16; i++) begin
            r = 5'($urandom_range(0, 31));
            d = 16'($urandom);
            do_write(2, 32, 32, OP_W, 5'd7, r, d, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            r = 5'($urandom_range(0, 31));
            do_read(2, 32, r, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
